// File: rtl/i2c_target_regfile_pkg.sv
// Shared types and constants for the I2C target register file.
// Latency: n/a (declarations only).
// Backpressure: n/a; the target never stretches SCL.
package i2c_pkg;

  localparam int BYTE_W = 8;

  // R/W bit carried in bit 0 of the address byte
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    INDEX,
    INDEX_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

endpackage

// File: rtl/i2c_target_regfile_bus_cond.sv
// Synchronizes SCL/SDA into clk and emits single-clk edge/condition pulses.
// Latency: SYNC_STAGES+1 clk from a pin change to its pulse.
// Backpressure: none; pulses are fire-and-forget.
// Ports: clk, i_rst_n (async active-low), i_scl/i_sda pins in;
//        o_sda (sampled level aligned with the pulses), o_scl_rise, o_scl_fall,
//        o_start_det, o_stop_det pulses out.
module i2c_bus_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   r_sda;
  logic                   r_scl_rise;
  logic                   r_scl_fall;
  logic                   r_start;
  logic                   r_stop;
  logic                   w_scl_cur;
  logic                   w_sda_cur;

  assign w_scl_cur = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_cur = r_sda_sync[SYNC_STAGES-1];

  // Chains reset to 1 (idle bus level) so leaving reset makes no false edge
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
      r_sda      <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_prev <= w_scl_cur;
      r_sda_prev <= w_sda_cur;
      r_sda      <= w_sda_cur;
      r_scl_rise <= w_scl_cur & ~r_scl_prev;
      r_scl_fall <= ~w_scl_cur & r_scl_prev;
      // SDA transitions only count as conditions while SCL stays high
      r_start    <= w_scl_cur & r_scl_prev & r_sda_prev & ~w_sda_cur;
      r_stop     <= w_scl_cur & r_scl_prev & ~r_sda_prev & w_sda_cur;
    end
  end

  assign o_sda       = r_sda;
  assign o_scl_rise  = r_scl_rise;
  assign o_scl_fall  = r_scl_fall;
  assign o_start_det = r_start;
  assign o_stop_det  = r_stop;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target: address match, index byte, byte-wide register file read/write.
// Latency: SDA drive follows an SCL fall by SYNC_STAGES+2 clk; commit at ACK-opening fall.
// Backpressure: none; never stretches SCL, out-of-range writes are ACKed and dropped.
// Ports: clk, RST_N (async active-low), SCL in, SDA open-drain inout,
//        regs_o (reg k at [8k+7:8k]), wr_strobe_o, wr_index_o, busy_o.
// Build option: I2C_TARGET_AUTOINC_EN makes the index advance after each data byte.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h55,
  parameter int         NUM_REGS    = 4,
  parameter logic [7:0] RESET_VAL   = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       RST_N,
  input  logic                       SCL,
  inout  wire                        SDA,
  output logic [NUM_REGS*BYTE_W-1:0] regs_o,
  output logic                       wr_strobe_o,
  output logic [BYTE_W-1:0]          wr_index_o,
  output logic                       busy_o
);

  localparam int              IDX_W    = $clog2(NUM_REGS);
  localparam logic [7:0]      NREGS_B  = 8'(NUM_REGS);
  localparam logic [3:0]      CNT_FULL = 4'(BYTE_W);

  logic [BYTE_W-1:0] r_regs [NUM_REGS];
  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [BYTE_W-1:0] r_shift;
  logic [BYTE_W-1:0] r_index;
  logic              r_rw;
  logic              r_mack;
  logic              r_sda_oe;
  logic              r_busy;
  logic              r_wr_strobe;
  logic [BYTE_W-1:0] r_wr_index;

  logic              w_sda;
  logic              w_scl_rise;
  logic              w_scl_fall;
  logic              w_start;
  logic              w_stop;
  logic [BYTE_W-1:0] w_idx_adv;
  logic [BYTE_W-1:0] w_rd_cur;
  logic [BYTE_W-1:0] w_rd_adv;

  i2c_bus_cond #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_cond (
    .clk        (clk),
    .i_rst_n    (RST_N),
    .i_scl      (SCL),
    .i_sda      (SDA),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start_det(w_start),
    .o_stop_det (w_stop)
  );

  // Open drain: only ever pull low or let go
  assign SDA = r_sda_oe ? 1'b0 : 1'bz;

`ifdef I2C_TARGET_AUTOINC_EN
  assign w_idx_adv = r_index + 8'd1;
`else
  assign w_idx_adv = r_index;
`endif

  // Read data for the current index and for the index after a data byte;
  // anything past the register file reads as all ones.
  always_comb begin
    w_rd_cur = 8'hFF;
    w_rd_adv = 8'hFF;
    if (r_index < NREGS_B) w_rd_cur = r_regs[r_index[IDX_W-1:0]];
    if (w_idx_adv < NREGS_B) w_rd_adv = r_regs[w_idx_adv[IDX_W-1:0]];
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_index     <= '0;
      r_rw        <= WRITE;
      r_mack      <= 1'b1;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_index  <= '0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VAL;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_start) begin
        // START and repeated START both restart address reception
        r_state  <= ADDR;
        r_cnt    <= '0;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_stop) begin
        r_state  <= IDLE;
        r_cnt    <= '0;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ADDR, INDEX, WR_DATA: begin
            if (w_scl_rise && r_cnt != CNT_FULL) begin
              r_shift <= {r_shift[BYTE_W-2:0], w_sda};
              r_cnt   <= r_cnt + 4'd1;
            end else if (w_scl_fall && r_cnt == CNT_FULL) begin
              // The fall after the 8th bit opens the ACK slot
              r_cnt <= '0;
              if (r_state == ADDR) begin
                if (r_shift[BYTE_W-1:1] == DEV_ADDR) begin
                  r_state  <= ADDR_ACK;
                  r_rw     <= r_shift[0];
                  r_sda_oe <= 1'b1;
                  r_busy   <= 1'b1;
                end else begin
                  r_state <= IGNORE;
                end
              end else if (r_state == INDEX) begin
                r_index  <= r_shift;
                r_sda_oe <= 1'b1;
                r_state  <= INDEX_ACK;
              end else begin
                if (r_index < NREGS_B) begin
                  r_regs[r_index[IDX_W-1:0]] <= r_shift;
                  r_wr_strobe                <= 1'b1;
                end
                r_wr_index <= r_index;
                r_index    <= w_idx_adv;
                r_sda_oe   <= 1'b1;
                r_state    <= WR_ACK;
              end
            end
          end
          ADDR_ACK: begin
            if (w_scl_fall) begin
              if (r_rw == READ) begin
                // The fall ending the ACK also puts the first data bit out
                r_shift  <= {w_rd_cur[BYTE_W-2:0], 1'b0};
                r_sda_oe <= ~w_rd_cur[BYTE_W-1];
                r_cnt    <= 4'd1;
                r_state  <= RD_DATA;
              end else begin
                r_sda_oe <= 1'b0;
                r_cnt    <= '0;
                r_state  <= INDEX;
              end
            end
          end
          INDEX_ACK, WR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_cnt    <= '0;
              r_state  <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (w_scl_fall) begin
              if (r_cnt == CNT_FULL) begin
                r_sda_oe <= 1'b0;
                r_cnt    <= '0;
                r_state  <= RD_ACK;
              end else begin
                r_sda_oe <= ~r_shift[BYTE_W-1];
                r_shift  <= {r_shift[BYTE_W-2:0], 1'b0};
                r_cnt    <= r_cnt + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (w_scl_rise) begin
              r_mack <= w_sda;
            end else if (w_scl_fall) begin
              if (!r_mack) begin
                r_index  <= w_idx_adv;
                r_shift  <= {w_rd_adv[BYTE_W-2:0], 1'b0};
                r_sda_oe <= ~w_rd_adv[BYTE_W-1];
                r_cnt    <= 4'd1;
                r_state  <= RD_DATA;
              end else begin
                r_state <= IGNORE;
              end
            end
          end
          default: begin
            // IDLE and IGNORE only leave on START/STOP
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign regs_o[k*BYTE_W +: BYTE_W] = r_regs[k];
  end

  assign wr_strobe_o = r_wr_strobe;
  assign wr_index_o  = r_wr_index;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, table of write transactions,
// plus hand-written read, burst and reset sequences.
module tb_i2c_target_regfile;

  localparam int Q = 5;   // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl;
  logic        m_low;
  wire         sda;
  logic [31:0] regs;
  logic        wr_strobe;
  logic [7:0]  wr_index;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int busy_cyc = 0;
  int drove_cyc = 0;

  always #5 clk = ~clk;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_target_regfile dut (
    .clk        (clk),
    .RST_N      (rst_n),
    .SCL        (scl),
    .SDA        (sda),
    .regs_o     (regs),
    .wr_strobe_o(wr_strobe),
    .wr_index_o (wr_index),
    .busy_o     (busy)
  );

  // Cumulative activity counters; sequences take differences around a transaction
  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt++;
    if (busy) busy_cyc++;
    if (!m_low && sda === 1'b0) drove_cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic m_start();
    m_low = 1'b1; wq(); scl = 1'b0; wq();
  endtask

  task automatic m_rstart();
    m_low = 1'b0; wq(); scl = 1'b1; wq(); m_low = 1'b1; wq(); scl = 1'b0; wq();
  endtask

  task automatic m_stop();
    m_low = 1'b1; wq(); scl = 1'b1; wq(); m_low = 1'b0; wq(); wq();
  endtask

  task automatic m_wbit(input logic b);
    m_low = ~b; wq(); scl = 1'b1; wq(); wq(); scl = 1'b0; wq();
  endtask

  task automatic m_rbit(output logic b);
    m_low = 1'b0; wq(); scl = 1'b1; wq(); b = sda; wq(); scl = 1'b0; wq();
  endtask

  task automatic m_wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) m_wbit(d[i]);
    m_rbit(ack);
  endtask

  task automatic m_rbyte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      m_rbit(b);
      d[i] = b;
    end
    m_wbit(mack);
  endtask

  typedef struct {
    logic [7:0]  dev;
    logic [7:0]  idx;
    logic [7:0]  dat;
    logic [2:0]  acks;     // 0 = ACK, for address/index/data slots
    logic [31:0] regs;
    int          strobes;
    logic [7:0]  widx;
    logic        busy;     // busy_o seen and SDA pulled by target
  } wvec_t;

  wvec_t       tbl [6];
  int          s0, b0, d0;
  logic        a0, a1, a2;
  logic [7:0]  rd0, rd1;

  initial begin
    tbl[0] = '{8'hAA, 8'h01, 8'hA5, 3'b000, 32'h0000_A500, 1, 8'h01, 1'b1};
    tbl[1] = '{8'h44, 8'h01, 8'h77, 3'b111, 32'h0000_A500, 0, 8'h01, 1'b0};
    tbl[2] = '{8'hAA, 8'h02, 8'h3C, 3'b000, 32'h003C_A500, 1, 8'h02, 1'b1};
    tbl[3] = '{8'hAA, 8'h00, 8'h5A, 3'b000, 32'h003C_A55A, 1, 8'h00, 1'b1};
    tbl[4] = '{8'hAA, 8'h05, 8'h99, 3'b000, 32'h003C_A55A, 0, 8'h05, 1'b1};
    tbl[5] = '{8'hAA, 8'h03, 8'hC3, 3'b000, 32'hC33C_A55A, 1, 8'h03, 1'b1};

    rst_n = 1'b0;
    scl   = 1'b1;
    m_low = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset regs", regs, 32'h0);
    chk("reset strobe", {31'd0, wr_strobe}, 32'd0);
    chk("reset wr_index", {24'd0, wr_index}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset sda", {31'd0, sda}, 32'd1);
    rst_n = 1'b1;
    wq();

    // Single-byte write transactions
    for (int v = 0; v < 6; v++) begin
      s0 = strobe_cnt; b0 = busy_cyc; d0 = drove_cyc;
      m_start();
      m_wbyte(tbl[v].dev, a0);
      m_wbyte(tbl[v].idx, a1);
      m_wbyte(tbl[v].dat, a2);
      m_stop();
      chk($sformatf("v%0d acks", v), {29'd0, a0, a1, a2}, {29'd0, tbl[v].acks});
      chk($sformatf("v%0d regs", v), regs, tbl[v].regs);
      chk($sformatf("v%0d strobes", v), 32'(strobe_cnt - s0), 32'(tbl[v].strobes));
      chk($sformatf("v%0d wr_index", v), {24'd0, wr_index}, {24'd0, tbl[v].widx});
      chk($sformatf("v%0d busy seen", v), {31'd0, busy_cyc != b0}, {31'd0, tbl[v].busy});
      chk($sformatf("v%0d sda driven", v), {31'd0, drove_cyc != d0}, {31'd0, tbl[v].busy});
      chk($sformatf("v%0d busy after stop", v), {31'd0, busy}, 32'd0);
    end

    // Read reg2 via repeated START, master NACK
    m_start();
    m_wbyte(8'hAA, a0);
    m_wbyte(8'h02, a1);
    m_rstart();
    m_wbyte(8'hAB, a2);
    chk("rd acks", {29'd0, a0, a1, a2}, 32'd0);
    m_rbyte(1'b1, rd0);
    chk("rd reg2", {24'd0, rd0}, 32'h3C);
    repeat (2) @(negedge clk);
    chk("rd sda released after nack", {31'd0, sda}, 32'd1);
    chk("rd busy before stop", {31'd0, busy}, 32'd1);
    m_stop();
    chk("rd busy after stop", {31'd0, busy}, 32'd0);

    // Out-of-range read
    m_start();
    m_wbyte(8'hAA, a0);
    m_wbyte(8'h07, a1);
    m_rstart();
    m_wbyte(8'hAB, a2);
    m_rbyte(1'b1, rd0);
    m_stop();
    chk("oor rd acks", {29'd0, a0, a1, a2}, 32'd0);
    chk("oor rd data", {24'd0, rd0}, 32'hFF);

    // Two-byte read from index 0
    m_start();
    m_wbyte(8'hAA, a0);
    m_wbyte(8'h00, a1);
    m_rstart();
    m_wbyte(8'hAB, a2);
    m_rbyte(1'b0, rd0);
    m_rbyte(1'b1, rd1);
    m_stop();
    chk("burst rd byte0", {24'd0, rd0}, 32'h5A);
`ifdef I2C_TARGET_AUTOINC_EN
    chk("burst rd byte1", {24'd0, rd1}, 32'hA5);
`else
    chk("burst rd byte1", {24'd0, rd1}, 32'h5A);
`endif

    // Burst write 0x11, 0x22, 0x33 at index 2
    s0 = strobe_cnt;
    m_start();
    m_wbyte(8'hAA, a0);
    m_wbyte(8'h02, a1);
    m_wbyte(8'h11, a2);
    chk("burst wr acks", {29'd0, a0, a1, a2}, 32'd0);
    m_wbyte(8'h22, a0);
    m_wbyte(8'h33, a1);
    chk("burst wr tail acks", {30'd0, a0, a1}, 32'd0);
    m_stop();
`ifdef I2C_TARGET_AUTOINC_EN
    chk("burst wr regs", regs, 32'h2211_A55A);
    chk("burst wr strobes", 32'(strobe_cnt - s0), 32'd2);
    chk("burst wr wr_index", {24'd0, wr_index}, 32'h04);
`else
    chk("burst wr regs", regs, 32'hC333_A55A);
    chk("burst wr strobes", 32'(strobe_cnt - s0), 32'd3);
    chk("burst wr wr_index", {24'd0, wr_index}, 32'h02);
`endif

    // Reset during data bit 4 of a write
    s0 = strobe_cnt;
    m_start();
    m_wbyte(8'hAA, a0);
    m_wbyte(8'h01, a1);
    chk("mid rst acks", {30'd0, a0, a1}, 32'd0);
    m_wbit(1'b1); m_wbit(1'b1); m_wbit(1'b1);
    m_low = 1'b0; wq(); scl = 1'b1; wq();
    rst_n = 1'b0;
    #1;
    chk("mid rst sda", {31'd0, sda}, 32'd1);
    chk("mid rst regs", regs, 32'h0);
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wq(); scl = 1'b0; wq();
    m_stop();
    chk("mid rst no strobe", 32'(strobe_cnt - s0), 32'd0);
    chk("mid rst wr_index", {24'd0, wr_index}, 32'd0);
    chk("mid rst regs after stop", regs, 32'h0);

    // Full transaction after reset
    s0 = strobe_cnt;
    m_start();
    m_wbyte(8'hAA, a0);
    m_wbyte(8'h01, a1);
    m_wbyte(8'h5C, a2);
    m_stop();
    chk("post rst acks", {29'd0, a0, a1, a2}, 32'd0);
    chk("post rst regs", regs, 32'h0000_5C00);
    chk("post rst strobe", 32'(strobe_cnt - s0), 32'd1);
    chk("post rst wr_index", {24'd0, wr_index}, 32'h01);

    // Reset while the target is holding the address ACK low
    m_start();
    for (int i = 7; i >= 0; i--) m_wbit(a0 ^ a0 ^ ((8'hAA >> i) & 8'h01) != 0);
    m_low = 1'b0;
    repeat (2) @(negedge clk);
    chk("ack slot driven", {31'd0, sda}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("ack slot rst sda", {31'd0, sda}, 32'd1);
    chk("ack slot rst regs", regs, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_stop();
    chk("ack slot rst busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
